// File: rtl/pipelined_addsub_if.sv
// Handshake/data bundle for pipelined_addsub.
//   master: upstream producer + downstream consumer side (drives operands and out_ready)
//   slave : the add/sub unit (drives in_ready and the result beat)
// Signals: in_valid/in_ready, a, b, sub, [sat], out_valid/out_ready, result, cout, ovf, zero.
// ADDSUB_SAT_EN: when defined, adds the per-beat saturation select `sat`.
interface pipelined_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
`ifdef ADDSUB_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub,
`ifdef ADDSUB_SAT_EN
        output sat,
`endif
        output out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub,
`ifdef ADDSUB_SAT_EN
        input  sat,
`endif
        input  out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract unit. The carry chain is cut into STAGES
// segments of SEG = WIDTH/STAGES bits, one register boundary per segment; latency is
// STAGES cycles with full 1 beat/cycle throughput and valid/ready backpressure.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus (slave): in_valid/in_ready, a, b, sub, [sat] in; out_valid/out_ready,
//                result, cout, ovf, zero out (all outputs registered except in_ready,
//                which is combinational from out_ready through the stall chain)
// ADDSUB_SAT_EN: when defined, sat=1 clamps overflowing results to the signed limits.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int unsigned SEG  = (STAGES == 0) ? WIDTH : WIDTH / STAGES;
    localparam int unsigned SEG1 = SEG + 1;

    if (STAGES == 0 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be summed when a beat enters this stage
        localparam int unsigned UPW = WIDTH - SEG * k;

        logic [UPW-1:0]       a_src;
        logic [UPW-1:0]       b_src;
        logic                 c_src;
        logic                 v_src;
`ifdef ADDSUB_SAT_EN
        logic                 sat_src;
`endif
        logic [SEG:0]         seg_sum;
        logic [(k+1)*SEG-1:0] r_next;
        logic                 v_q;
        logic                 en;

        // Stage input: raw operands (b inverted, carry-in = sub) or previous stage regs
        if (k == 0) begin : g_first
            assign a_src  = bus.a;
            assign b_src  = bus.sub ? ~bus.b : bus.b;
            assign c_src  = bus.sub;
            assign v_src  = bus.in_valid;
`ifdef ADDSUB_SAT_EN
            assign sat_src = bus.sat;
`endif
            assign r_next = seg_sum[SEG-1:0];
        end else begin : g_next
            assign a_src  = g_stage[k-1].g_mid.a_q;
            assign b_src  = g_stage[k-1].g_mid.b_q;
            assign c_src  = g_stage[k-1].g_mid.c_q;
            assign v_src  = g_stage[k-1].v_q;
`ifdef ADDSUB_SAT_EN
            assign sat_src = g_stage[k-1].g_mid.sat_q;
`endif
            assign r_next = {seg_sum[SEG-1:0], g_stage[k-1].g_mid.r_q};
        end

        // This stage's segment of the carry chain
        assign seg_sum = {1'b0, a_src[SEG-1:0]} + {1'b0, b_src[SEG-1:0]} + SEG1'(c_src);

        if (k < STAGES - 1) begin : g_mid
            logic [UPW-SEG-1:0]   a_q;
            logic [UPW-SEG-1:0]   b_q;
            logic [(k+1)*SEG-1:0] r_q;
            logic                 c_q;
`ifdef ADDSUB_SAT_EN
            logic                 sat_q;
`endif

            // Load when empty or when the successor is taking the current beat
            assign en = !v_q || g_stage[k+1].en;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    r_q   <= '0;
                    c_q   <= 1'b0;
`ifdef ADDSUB_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (en) begin
                    v_q <= v_src;
                    if (v_src) begin
                        a_q   <= a_src[UPW-1:SEG];
                        b_q   <= b_src[UPW-1:SEG];
                        r_q   <= r_next;
                        c_q   <= seg_sum[SEG];
`ifdef ADDSUB_SAT_EN
                        sat_q <= sat_src;
`endif
                    end
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] res_c;
            logic             cout_c;
            logic             ovf_c;
            logic             cin_msb;
            logic [WIDTH-1:0] result_q;
            logic             cout_q;
            logic             ovf_q;
            logic             zero_q;

            assign en      = !v_q || bus.out_ready;
            assign cout_c  = seg_sum[SEG];
            // Carry into the MSB recovered from the MSB sum bit and its operands
            assign cin_msb = a_src[SEG-1] ^ b_src[SEG-1] ^ seg_sum[SEG-1];
            assign ovf_c   = cin_msb ^ cout_c;

`ifdef ADDSUB_SAT_EN
            // Overflow implies equal operand signs; a's sign picks the clamp direction
            always_comb begin
                res_c = r_next;
                if (sat_src && ovf_c) begin
                    res_c = a_src[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign res_c = r_next;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q      <= 1'b0;
                    result_q <= '0;
                    cout_q   <= 1'b0;
                    ovf_q    <= 1'b0;
                    zero_q   <= 1'b0;
                end else if (en) begin
                    v_q <= v_src;
                    if (v_src) begin
                        result_q <= res_c;
                        cout_q   <= cout_c;
                        ovf_q    <= ovf_c;
                        zero_q   <= (res_c == '0);
                    end
                end
            end

            assign bus.out_valid = v_q;
            assign bus.result    = result_q;
            assign bus.cout      = cout_q;
            assign bus.ovf       = ovf_q;
            assign bus.zero      = zero_q;
        end
    end

    assign bus.in_ready = g_stage[0].en;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (32/4, 32/1, 16/16) share one stimulus
// stream; each has its own in-order scoreboard fed by an arithmetic reference model.
module tb_pipelined_addsub;
    typedef struct {
        logic [31:0] result;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        exp_t        e;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sat;

    logic        rdy_w  [3];
    logic        ov_w   [3];
    logic [31:0] res_w  [3];
    logic        cout_w [3];
    logic        ovf_w  [3];
    logic        zero_w [3];

    int   n_checks;
    int   n_fail;
    exp_t exp_q [3][$];
    int   n_acc [3];
    int   n_out [3];
    logic acc   [3];

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned W = (g == 2) ? 16 : 32;
        localparam int unsigned S = (g == 0) ? 4 : ((g == 1) ? 1 : 16);

        pipelined_addsub_if #(.WIDTH(W)) bus ();

        pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.in_valid  = in_valid;
        assign bus.a         = W'(a);
        assign bus.b         = W'(b);
        assign bus.sub       = sub;
`ifdef ADDSUB_SAT_EN
        assign bus.sat       = sat;
`endif
        assign bus.out_ready = out_ready;
        assign rdy_w[g]      = bus.in_ready;
        assign ov_w[g]       = bus.out_valid;
        assign res_w[g]      = 32'(bus.result);
        assign cout_w[g]     = bus.cout;
        assign ovf_w[g]      = bus.ovf;
        assign zero_w[g]     = bus.zero;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int w_of(input int d);
        return (d == 2) ? 16 : 32;
    endfunction

    function automatic int s_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    // Reference: true signed/unsigned arithmetic on w-bit operands
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic s, input logic st);
        exp_t            e;
        longint unsigned full;
        longint unsigned ua;
        longint unsigned ub;
        longint          sa;
        longint          sb;
        longint          maxv;
        longint          minv;
        longint          tot;
        full = 64'd1 << w;
        ua   = {32'd0, av} & (full - 1);
        ub   = {32'd0, bv} & (full - 1);
        sa   = (ua >= full / 2) ? longint'(ua) - longint'(full) : longint'(ua);
        sb   = (ub >= full / 2) ? longint'(ub) - longint'(full) : longint'(ub);
        maxv = longint'(full / 2) - 1;
        minv = -longint'(full / 2);
        tot  = s ? sa - sb : sa + sb;
        e.ovf = (tot > maxv) || (tot < minv);
        if (st && e.ovf) tot = (tot > maxv) ? maxv : minv;
        e.result = 32'(longint'(tot) & longint'(full - 1));
        e.cout   = s ? (ua >= ub) : ((ua + ub) >= full);
        e.zero   = (e.result == 32'd0);
        return e;
    endfunction

    task automatic check_out(input string name, input int d, input exp_t e);
        n_checks++;
        if (res_w[d] !== e.result || cout_w[d] !== e.cout || ovf_w[d] !== e.ovf ||
            zero_w[d] !== e.zero) begin
            n_fail++;
            $display("FAIL %s: got result=%h cout=%b ovf=%b zero=%b, required result=%h cout=%b ovf=%b zero=%b",
                     name, res_w[d], cout_w[d], ovf_w[d], zero_w[d], e.result, e.cout, e.ovf, e.zero);
        end
    endtask

    task automatic check_val(input string name, input longint got, input longint req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Sample handshakes of all instances; scoreboard every accepted/emitted beat
    task automatic monitor();
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            acc[d] = 1'b0;
            if (!rst_n) begin
                exp_q[d].delete();
                n_acc[d] = 0;
                n_out[d] = 0;
            end else begin
                if (in_valid && rdy_w[d]) begin
                    exp_q[d].push_back(model(w_of(d), a, b, sub, sat));
                    acc[d] = 1'b1;
                    n_acc[d]++;
                end
                if (ov_w[d] && out_ready) begin
                    n_out[d]++;
                    if (exp_q[d].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_extra_dut%0d: got beat result=%h, required no beat", d, res_w[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        check_out($sformatf("sb_dut%0d", d), d, e);
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // Single beat into empty pipes; checks DUT0 outputs and every instance's latency
    task automatic run_one(input string name, input logic [31:0] av, input logic [31:0] bv,
                           input logic sv, input logic stv, input exp_t e);
        int lat [3];
        a = av; b = bv; sub = sv; sat = stv; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat = '{0, 0, 0};
        for (int c = 1; c <= 20; c++) begin
            for (int d = 0; d < 3; d++) begin
                if (ov_w[d] && lat[d] == 0) begin
                    lat[d] = c;
                    if (d == 0) check_out(name, 0, e);
                end
            end
            cycle();
        end
        for (int d = 0; d < 3; d++)
            check_val($sformatf("%s_latency_dut%0d", name, d), lat[d], s_of(d));
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0000_8000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        vec_t        vt [10];
        int          cnt;
        int          n_low;
        int          n_chg;
        int          start;
        logic        have;
        logic [31:0] snap_r;
        logic [2:0]  snap_f;

        vt[0] = '{32'h0000_000A, 32'h0000_0003, 1'b1, '{32'h0000_0007, 1'b1, 1'b0, 1'b0}};
        vt[1] = '{32'h0000_0003, 32'h0000_000A, 1'b1, '{32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0}};
        vt[2] = '{32'h1234_5678, 32'h1234_5678, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vt[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vt[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vt[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        vt[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
        vt[7] = '{32'h0000_0000, 32'h8000_0000, 1'b1, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vt[8] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, '{32'h2222_2221, 1'b0, 1'b0, 1'b0}};
        vt[9] = '{32'h0001_0000, 32'h0000_0001, 1'b1, '{32'h0000_FFFF, 1'b1, 1'b0, 1'b0}};

        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_dut0", 0, '{32'h0, 1'b0, 1'b0, 1'b0});
        for (int d = 0; d < 3; d++) check_val($sformatf("reset_out_valid_dut%0d", d), ov_w[d], 0);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check_val($sformatf("reset_in_ready_dut%0d", d), rdy_w[d], 1);

        // Directed vectors
        for (int i = 0; i < 10; i++)
            run_one($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sub, 1'b0, vt[i].e);
`ifdef ADDSUB_SAT_EN
        run_one("sat_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
        run_one("sat_neg", 32'h8000_0000, 32'h1, 1'b1, 1'b1, '{32'h8000_0000, 1'b1, 1'b1, 1'b0});
`endif

        // Back-to-back beats: one result per cycle after the fill
        in_valid = 1'b1; out_ready = 1'b1; cnt = 0; n_low = 0;
        for (int c = 0; c < 16; c++) begin
            a = $urandom(); b = $urandom(); sub = 1'($urandom_range(1));
            if (!rdy_w[0]) n_low++;
            cycle();
            if (c >= 3 && ov_w[0]) cnt++;
        end
        in_valid = 1'b0;
        for (int c = 16; c < 19; c++) begin
            cycle();
            if (ov_w[0]) cnt++;
        end
        check_val("stream_in_ready_low", n_low, 0);
        check_val("stream_results", cnt, 16);
        repeat (20) cycle();

        // Stall: 4 beats fill the pipe, then in_ready drops and outputs hold
        out_ready = 1'b0; in_valid = 1'b1; cnt = 0; n_chg = 0; have = 1'b0;
        snap_r = '0; snap_f = '0;
        for (int c = 0; c < 10; c++) begin
            a = rand_op(); b = rand_op(); sub = 1'($urandom_range(1));
            cycle();
            if (acc[0]) cnt++;
            if (ov_w[0]) begin
                if (!have) begin
                    have = 1'b1; snap_r = res_w[0]; snap_f = {cout_w[0], ovf_w[0], zero_w[0]};
                end else if (res_w[0] !== snap_r || {cout_w[0], ovf_w[0], zero_w[0]} !== snap_f) begin
                    n_chg++;
                end
            end
        end
        check_val("stall_accepted", cnt, 4);
        check_val("stall_in_ready", rdy_w[0], 0);
        check_val("stall_out_valid", ov_w[0], 1);
        check_val("stall_outputs_changed", n_chg, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (25) cycle();

        // Reset with beats in flight
        out_ready = 1'b0; in_valid = 1'b1;
        a = 32'h7FFF_FFFF; b = 32'h1; sub = 1'b0;
        cycle();
        for (int c = 0; c < 3; c++) begin
            a = $urandom(); b = $urandom();
            cycle();
        end
        in_valid = 1'b0;
        check_val("pre_reset_out_valid", ov_w[0], 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_reset_out_valid", ov_w[0], 0);
        check_out("mid_reset_flags", 0, '{32'h0, 1'b0, 1'b0, 1'b0});
        repeat (3) cycle();
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check_val($sformatf("post_reset_in_ready_dut%0d", d), rdy_w[d], 1);
        out_ready = 1'b1; cnt = 0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            for (int d = 0; d < 3; d++) if (ov_w[d]) cnt++;
        end
        check_val("stale_beats", cnt, 0);

        // Random traffic against the model
        start = n_acc[0];
        for (int c = 0; c < 3000 && (n_acc[0] - start) < 100; c++) begin
            in_valid  = ($urandom_range(99) < 70);
            out_ready = 1'($urandom_range(1));
            a = rand_op(); b = rand_op(); sub = 1'($urandom_range(1));
`ifdef ADDSUB_SAT_EN
            sat = 1'($urandom_range(1));
`endif
            cycle();
        end
        check_val("random_beats_reached_100", ((n_acc[0] - start) >= 100) ? 1 : 0, 1);
        in_valid = 1'b0; out_ready = 1'b1; sat = 1'b0;
        repeat (40) cycle();
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("drain_pending_dut%0d", d), exp_q[d].size(), 0);
            check_val($sformatf("beats_in_vs_out_dut%0d", d), n_out[d], n_acc[d]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
